// File: rtl/sm_pkg.sv
// Shared definitions for the scoring-module target loader:
// 2-bit base codes, ASCII base characters and the loader FSM state encoding.
package sm_pkg;

  // 2-bit base codes as packed into the target word
  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;
  localparam logic [1:0] BASE_G = 2'b10;
  localparam logic [1:0] BASE_T = 2'b11;

  // ASCII characters accepted as bases (upper and lower case)
  localparam logic [7:0] ASCII_A_UC = 8'h41;
  localparam logic [7:0] ASCII_C_UC = 8'h43;
  localparam logic [7:0] ASCII_G_UC = 8'h47;
  localparam logic [7:0] ASCII_T_UC = 8'h54;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_C_LC = 8'h63;
  localparam logic [7:0] ASCII_G_LC = 8'h67;
  localparam logic [7:0] ASCII_T_LC = 8'h74;

  // Loader FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_t;

endpackage

// File: rtl/sm_target_loader_if.sv
// Stream-in and feeder-side signals of the target loader.
//
// Handshake: a beat transfers on every rising clk edge where in_valid and
// in_ready are both high. The source holds in_data/in_sop/in_eop/in_id
// stable while in_valid is high and not yet accepted; in_ready may be low
// without in_valid and never depends combinationally on in_valid.
// On the feeder side, ld is a one-cycle strobe; feed_out is valid on it.
interface sm_target_loader_if #(
  parameter int TARGET_LENGTH = 128,
  parameter int LEN_WIDTH     = 12,
  parameter int ID_WIDTH      = 48
);
  localparam int IN_WIDTH = ID_WIDTH + LEN_WIDTH + 2 * TARGET_LENGTH;

  logic                in_valid;
  logic                in_ready;
  logic [7:0]          in_data;
  logic                in_sop;
  logic                in_eop;
  logic [ID_WIDTH-1:0] in_id;
  logic                full;
  logic                ld;
  logic [IN_WIDTH-1:0] feed_out;

  // Upstream source plus feeder (drives stream and full, sees ld/record)
  modport master (
    output in_valid, in_data, in_sop, in_eop, in_id, full,
    input  in_ready, ld, feed_out
  );

  // The loader itself
  modport slave (
    input  in_valid, in_data, in_sop, in_eop, in_id, full,
    output in_ready, ld, feed_out
  );
endinterface

// File: rtl/sm_base_decode.sv
// Combinational base decoder: 8-bit input beat to 2-bit base code plus an
// invalid-character flag.
// SM_LOADER_ASCII_EN defined : case-insensitive ASCII A/C/G/T; anything
//                              else decodes to A and raises invalid.
// SM_LOADER_ASCII_EN undefined: data[1:0] is the code, invalid is 0.
module sm_base_decode
  import sm_pkg::*;
(
  input  logic [7:0] data,
  output logic [1:0] code,
  output logic       invalid
);

`ifdef SM_LOADER_ASCII_EN
  // ASCII character to base code
  always_comb begin
    code    = BASE_A;
    invalid = 1'b0;
    case (data)
      ASCII_A_UC, ASCII_A_LC: code = BASE_A;
      ASCII_C_UC, ASCII_C_LC: code = BASE_C;
      ASCII_G_UC, ASCII_G_LC: code = BASE_G;
      ASCII_T_UC, ASCII_T_LC: code = BASE_T;
      default: begin
        code    = BASE_A;
        invalid = 1'b1;
      end
    endcase
  end
`else
  // Raw 2-bit code; the upper bits carry nothing
  logic unused_hi;
  assign code      = data[1:0];
  assign invalid   = 1'b0;
  assign unused_hi = ^data[7:2];
`endif

endmodule

// File: rtl/sm_target_loader.sv
// Target loader: collects a streamed base sequence, packs it 2 bits per
// base LSB-first, and hands the {ID, LENGTH, TARGET} record to the feeder
// with a registered one-cycle ld strobe once the feeder is not full.
// Optional build macro: SM_LOADER_ASCII_EN (ASCII base input with
// bad_base detection; otherwise raw 2-bit codes and bad_base stays 0).
module sm_target_loader
  import sm_pkg::*;
#(
  parameter int TARGET_LENGTH = 128,
  parameter int LEN_WIDTH     = 12,
  parameter int ID_WIDTH      = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  sm_target_loader_if.slave    bus,
  input  logic                 clr_err,
  output logic                 busy,
  output logic                 overflow,
  output logic                 bad_base,
  output state_t               state_dbg
);

  localparam int                   TGT_W   = 2 * TARGET_LENGTH;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(TARGET_LENGTH);

  state_t               state, state_n;
  logic                 ready_q;
  logic                 ld_q, ld_n;
  logic [ID_WIDTH-1:0]  id_q;
  logic [LEN_WIDTH-1:0] count_q;
  logic [TGT_W-1:0]     target_q;
  logic                 overflow_q;
  logic                 bad_base_q;

  logic [1:0]           code;
  logic                 invalid;
  logic                 accept;
  logic                 start;
  logic                 in_coll;
  logic                 has_room;
  logic                 store;
  logic                 drop_ovf;

  sm_base_decode u_decode (
    .data    (bus.in_data),
    .code    (code),
    .invalid (invalid)
  );

  // Beat qualification: sop always (re)starts, other beats store only
  // while collecting and below the length limit
  assign accept   = bus.in_valid & bus.in_ready;
  assign start    = accept & bus.in_sop;
  assign in_coll  = (state == COLLECT);
  assign has_room = (count_q < MAX_LEN);
  assign store    = accept & ~bus.in_sop & in_coll & has_room;
  assign drop_ovf = accept & ~bus.in_sop & in_coll & ~has_room;

  // Next state and ld request; ld is registered so it never follows full
  // combinationally
  always_comb begin
    state_n = state;
    ld_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = bus.in_eop ? PRESENT : COLLECT;
      end
      COLLECT: begin
        if (accept && bus.in_eop) state_n = PRESENT;
      end
      PRESENT: begin
        if (!bus.full) begin
          ld_n    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register plus registered in_ready and ld; in_ready is held low
  // through reset and drops as soon as PRESENT is entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      state   <= state_n;
      ready_q <= (state_n != PRESENT);
      ld_q    <= ld_n;
    end
  end

  // Record datapath: sop clears and seeds the target, later beats OR their
  // code into the slot selected by the current count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_q     <= '0;
      count_q  <= '0;
      target_q <= '0;
    end else if (start) begin
      id_q     <= bus.in_id;
      count_q  <= LEN_WIDTH'(1);
      target_q <= TGT_W'(code);
    end else if (store) begin
      count_q  <= count_q + LEN_WIDTH'(1);
      target_q <= target_q | (TGT_W'(code) << (2 * count_q));
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
      bad_base_q <= 1'b0;
    end else begin
      if (drop_ovf)     overflow_q <= 1'b1;
      else if (clr_err) overflow_q <= 1'b0;
      if ((start || store) && invalid) bad_base_q <= 1'b1;
      else if (clr_err)                bad_base_q <= 1'b0;
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.ld       = ld_q;
  assign bus.feed_out = {id_q, count_q, target_q};
  assign busy         = (state != IDLE);
  assign overflow     = overflow_q;
  assign bad_base     = bad_base_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_sm_target_loader.sv
// Bench for sm_target_loader (TARGET_LENGTH=8). Records expected on each
// ld are queued by the stimulus; a negedge monitor pops and compares.
// Works with or without SM_LOADER_ASCII_EN.
module tb_sm_target_loader;
  import sm_pkg::*;

  localparam int TL = 8;
  localparam int LW = 12;
  localparam int IW = 48;
  localparam int TW = 2 * TL;
  localparam int FW = IW + LW + TW;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   clr_err = 1'b0;
  logic   busy, overflow, bad_base;
  state_t state_dbg;

  always #5 clk = ~clk;

  sm_target_loader_if #(.TARGET_LENGTH(TL), .LEN_WIDTH(LW), .ID_WIDTH(IW)) bus ();

  sm_target_loader #(.TARGET_LENGTH(TL), .LEN_WIDTH(LW), .ID_WIDTH(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_err   (clr_err),
    .busy      (busy),
    .overflow  (overflow),
    .bad_base  (bad_base),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [FW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] rec(input logic [IW-1:0] id, input int len,
                                        input logic [TW-1:0] tgt);
    return {id, LW'(len), tgt};
  endfunction

  // One base character for the current build
  function automatic logic [7:0] enc(input logic [1:0] c);
`ifdef SM_LOADER_ASCII_EN
    case (c)
      2'd0:    return ASCII_A_UC;
      2'd1:    return ASCII_C_LC;
      2'd2:    return ASCII_G_UC;
      default: return ASCII_T_LC;
    endcase
`else
    return {6'b101101, c};
`endif
  endfunction

  // Monitor: every ld must match the oldest expected record
  always @(negedge clk) begin
    if (rst && bus.ld) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ld_unexpected: got ld=1 record %h, want no ld", bus.feed_out);
      end else begin
        chk("ld_record", bus.feed_out, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic beat(input logic [7:0] d, input logic sop, input logic eop,
                      input logic [IW-1:0] id);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sop   = sop;
    bus.in_eop   = eop;
    bus.in_id    = id;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL beat_ready_timeout: got in_ready=0 for %0d cycles, want 1", n);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  task automatic wait_ld(input string name);
    int n = 0;
    @(negedge clk);
    while (!bus.ld && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ld) begin
      total++;
      bad++;
      $display("FAIL %s_ld_timeout: got no ld in %0d cycles, want ld", name, n);
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_ld"},       bus.ld,       '0);
    chk({name, "_in_ready"}, bus.in_ready, '0);
    chk({name, "_busy"},     busy,         '0);
    chk({name, "_feed_out"}, bus.feed_out, '0);
    chk({name, "_overflow"}, overflow,     '0);
    chk({name, "_bad_base"}, bad_base,     '0);
    chk({name, "_state"},    state_dbg,    IDLE);
  endtask

  // Hard stop if something hangs
  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, want finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]    ov [10];
    logic [7:0]    t4 [4];
    logic [TW-1:0] t4_tgt;
    logic          t4_bad;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
    bus.in_id    = '0;
    bus.full     = 1'b0;

    // reset state
    #3 rst = 1'b0;
    #2 chk_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // ACGT, full=0: ld one cycle after PRESENT entry
    exp_q.push_back(rec(48'hA1B2_C3D4_E5F6, 4, 16'h00E4));
    beat(enc(2'd0), 1'b1, 1'b0, 48'hA1B2_C3D4_E5F6);
    beat(enc(2'd1), 1'b0, 1'b0, '0);
    beat(enc(2'd2), 1'b0, 1'b0, '0);
    beat(enc(2'd3), 1'b0, 1'b1, '0);
    @(negedge clk);
    chk("acgt_present", state_dbg, PRESENT);
    chk("acgt_ld_early", bus.ld, 1'b0);
    chk("acgt_in_ready_low", bus.in_ready, 1'b0);
    @(negedge clk);
    chk("acgt_ld_latency", bus.ld, 1'b1);
    @(negedge clk);
    chk("acgt_ld_once", bus.ld, 1'b0);
    chk("acgt_busy_idle", busy, 1'b0);

    // single G with full held: no ld, record stable, then exactly one ld
    bus.full = 1'b1;
    exp_q.push_back(rec(48'h0000_0000_0BEE, 1, 16'h0002));
    beat(enc(2'd2), 1'b1, 1'b1, 48'h0000_0000_0BEE);
    repeat (5) begin
      @(negedge clk);
      chk("full_ld_held", bus.ld, 1'b0);
      chk("full_feed_stable", bus.feed_out, rec(48'h0000_0000_0BEE, 1, 16'h0002));
    end
    @(posedge clk); #1;
    bus.full = 1'b0;
    wait_ld("full");
    @(negedge clk);
    chk("full_ld_once", bus.ld, 1'b0);

    // overflow: 10 bases into an 8-base target
    ov = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd1};
    exp_q.push_back(rec(48'h0000_0000_0F10, 8, 16'h1BE4));
    for (int i = 0; i < 10; i++)
      beat(enc(ov[i]), (i == 0), (i == 9), 48'h0000_0000_0F10);
    wait_ld("ovf");
    @(posedge clk); #1;
    chk("ovf_flag_set", overflow, 1'b1);
    chk("ovf_no_bad_base", bad_base, 1'b0);
    pulse_clr();
    chk("ovf_flag_cleared", overflow, 1'b0);

    // invalid character in third position
`ifdef SM_LOADER_ASCII_EN
    t4     = '{8'h61, 8'h63, 8'h4E, 8'h54};   // "acNT"
    t4_tgt = 16'h00C4;
    t4_bad = 1'b1;
`else
    t4     = '{8'hFC, 8'h01, 8'h03, 8'h07};
    t4_tgt = 16'h00F4;
    t4_bad = 1'b0;
`endif
    exp_q.push_back(rec(48'h0000_0000_0444, 4, t4_tgt));
    for (int i = 0; i < 4; i++)
      beat(t4[i], (i == 0), (i == 3), 48'h0000_0000_0444);
    wait_ld("badch");
    @(posedge clk); #1;
    chk("badch_flag", bad_base, t4_bad);
    pulse_clr();
    chk("badch_flag_cleared", bad_base, 1'b0);

    // sop restart after 3 bases, then a 2-base sequence (C,T)
    exp_q.push_back(rec(48'h0000_0000_0B0B, 2, 16'h000D));
    beat(enc(2'd2), 1'b1, 1'b0, 48'h0000_0000_0A0A);
    beat(enc(2'd2), 1'b0, 1'b0, '0);
    beat(enc(2'd2), 1'b0, 1'b0, '0);
    beat(enc(2'd1), 1'b1, 1'b0, 48'h0000_0000_0B0B);
    beat(enc(2'd3), 1'b0, 1'b1, '0);
    wait_ld("restart");
    @(negedge clk);
    chk("restart_ld_once", bus.ld, 1'b0);

    // reset during COLLECT: outputs clear at once, nothing emitted
    beat(enc(2'd1), 1'b1, 1'b0, 48'h0000_0000_0666);
    beat(enc(2'd1), 1'b0, 1'b0, '0);
    chk("rst_coll_busy_before", busy, 1'b1);
    #2 rst = 1'b0;
    #1 chk_zero_outputs("rst_coll");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // reset during PRESENT with full=1
    bus.full = 1'b1;
    beat(enc(2'd3), 1'b1, 1'b1, 48'h0000_0000_0777);
    @(negedge clk);
    chk("rst_pres_state_before", state_dbg, PRESENT);
    #2 rst = 1'b0;
    #1 chk_zero_outputs("rst_pres");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bus.full = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // non-sop beats in IDLE are dropped
    beat(enc(2'd0), 1'b0, 1'b0, 48'h0000_0000_0888);
    beat(enc(2'd1), 1'b0, 1'b1, '0);
    @(negedge clk);
    chk("nosop_state", state_dbg, IDLE);
    chk("nosop_busy", busy, 1'b0);
    chk("nosop_feed_out", bus.feed_out, '0);

    // normal sequence afterwards (T,A)
    exp_q.push_back(rec(48'h0000_0000_0999, 2, 16'h0003));
    beat(enc(2'd3), 1'b1, 1'b0, 48'h0000_0000_0999);
    beat(enc(2'd0), 1'b0, 1'b1, '0);
    wait_ld("post");

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sm_target_loader.md
Name: sm_target_loader

Overview:
Upstream neighbour of the scoring-module feeder. Accepts a streamed target sequence one base per beat over a valid/ready handshake. Packs the bases 2 bits each, LSB-first, into a target word and counts the length. Presents the finished {ID, LENGTH, TARGET} record on feed_out and issues a one-cycle ld pulse once the feeder reports not full.

Parameters:
TARGET_LENGTH, 128, maximum bases per target; packed field is 2*TARGET_LENGTH bits.
LEN_WIDTH, 12, width of the length field.
ID_WIDTH, 48, width of the sequence ID.
IN_WIDTH, ID_WIDTH+LEN_WIDTH+2*TARGET_LENGTH, width of feed_out (derived; do not override).

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-low reset.
in_valid  in  1  base beat valid.
in_ready  out  1  loader accepts a beat this cycle.
in_data  in  8  base (ASCII, or 2-bit code in [1:0]; see Optional Feature).
in_sop  in  1  first base of a sequence; qualified by in_valid.
in_eop  in  1  last base of a sequence; qualified by in_valid.
in_id  in  ID_WIDTH  sequence ID, sampled on the accepted sop beat.
full  in  1  feeder full flag.
ld  out  1  one-cycle load strobe to the feeder.
feed_out  out  IN_WIDTH  record: [IN_WIDTH-1 -: ID_WIDTH]=ID, next LEN_WIDTH=LENGTH, [2*TARGET_LENGTH-1:0]=TARGET.
busy  out  1  high in COLLECT or PRESENT.
overflow  out  1  sticky: a sequence exceeded TARGET_LENGTH.
bad_base  out  1  sticky: a non-ACGT character was received.
clr_err  in  1  synchronous clear of overflow and bad_base.

Behaviour:
- Reset (async, rst=0): state IDLE; ld=0, in_ready=0, busy=0, feed_out=0, overflow=0, bad_base=0. Base counter=0, target shift register=0. A partial sequence is discarded; nothing is emitted after reset.
- Beat accepted when in_valid & in_ready. in_ready=1 in IDLE and COLLECT, 0 in PRESENT.
- Encoding: A=00, C=01, G=10, T=11. Base k (0-based) occupies TARGET bits [2k+1:2k], so the feeder's right shift emits bases in arrival order. Unused upper bits are 0.
- FSM:
  - IDLE: accepted beat without sop is dropped. Accepted sop beat: latch in_id, clear target, store base 0, count=1, then go to COLLECT (or PRESENT if eop is also set).
  - COLLECT: each accepted beat stores a base and increments count. Beat with eop goes to PRESENT. Beat with sop restarts the sequence as in IDLE (the old partial is dropped, no error).
  - PRESENT: feed_out holds the record. If full=0 in a cycle, ld=1 in the next cycle (registered, exactly one cycle), then go to IDLE. ld never depends combinationally on full.
- Length: LENGTH = count, zero-extended to LEN_WIDTH. When count would exceed TARGET_LENGTH, further bases are dropped (still handshaken), count saturates at TARGET_LENGTH, and overflow sets.
- feed_out stays stable from PRESENT entry until the next accepted sop. The feeder may sample it on the ld cycle.
- clr_err together with a new error event in the same cycle: the set wins.
- Minimum spacing between ld pulses is 2 cycles (a 1-base sequence plus PRESENT).

Optional Feature:
SM_LOADER_ASCII_EN.
- Defined: in_data is ASCII, case-insensitive. A/a=00, C/c=01, G/g=10, T/t=11. Any other character stores 00, counts as a base, and sets bad_base.
- Undefined: in_data[1:0] is used directly as the 2-bit code, in_data[7:2] is ignored, and bad_base is tied to 0.

Decomposition:
- Shared package/header sm_pkg: base-code constants (BASE_A..BASE_T), ASCII constants, and the FSM state encodings (IDLE, COLLECT, PRESENT).
- One sub-module, sm_base_decode: combinational 8-bit to 2-bit code plus invalid flag, wrapped by SM_LOADER_ASCII_EN.

Test Plan:
- "ACGT" with ASCII_EN, sop on A, eop on T, full=0 -> ld one cycle after PRESENT entry; TARGET[7:0]=8'b11100100, LENGTH=4, ID=in_id, other TARGET bits 0.
- Single beat with sop=eop=1, "G", full held 1 for 5 cycles -> ld stays 0 and feed_out stable throughout; after full falls, ld=1 exactly once with LENGTH=1, TARGET[1:0]=10.
- TARGET_LENGTH=4, send 6 bases -> LENGTH=4, bases 5-6 dropped, overflow=1; clr_err clears it.
- "ACNT" -> bad_base=1, TARGET[5:4]=00, LENGTH=4; without macro, in_data=8'h03 maps to 11 and bad_base stays 0.
- sop restart mid-COLLECT after 3 bases, then 2-base sequence -> single ld with LENGTH=2 and the new ID.
- rst pulled low during COLLECT and during PRESENT (full=1) -> all outputs 0 immediately, no ld after release; non-sop beats in IDLE are dropped.
